// File: rtl/axi_wr_cmd_decoder.sv
// Write-side command decoder: pops header/address/data words from a command FIFO and drives
// one AXI4 write transaction at a time. Optional BID check built when AXI_WR_DEC_RESP_CHK_EN is defined.
module axi_wr_cmd_decoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  AClk,
  input  logic                  ARst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [3:0]            TXN_ID_W_d,
  output logic [ADDR_WIDTH-1:0] awaddr_d,
  output logic [7:0]            awlen_d,
  output logic [2:0]            awsize_d,
  output logic [1:0]            awburst_d,
  output logic [1:0]            awlock_d,
  output logic [1:0]            awcache_d,
  output logic [2:0]            awprot_d,
  output logic                  wr_trn_en,
  output logic [DATA_WIDTH-1:0] wdata_d,
  output logic [3:0]            wstrb_d,
  output logic                  wvalid_d,
  input  logic                  wd_accept,
  input  logic [1:0]            bresp_d,
  input  logic [3:0]            bid_d,
  input  logic                  wr_rsp_en_d,
  output logic                  sts_wr_en,
  output logic [7:0]            sts_data,
  output logic                  busy,
  output logic [15:0]           txn_cnt,
  output logic [15:0]           err_cnt,
  output logic                  id_err
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] HDR      = 4'd1;
  localparam logic [3:0] ADDR_POP = 4'd2;
  localparam logic [3:0] ADDR     = 4'd3;
  localparam logic [3:0] ISSUE    = 4'd4;
  localparam logic [3:0] DATA_POP = 4'd5;
  localparam logic [3:0] DATA_LD  = 4'd6;
  localparam logic [3:0] DATA     = 4'd7;
  localparam logic [3:0] RESP     = 4'd8;

  logic [3:0]            state_q, state_d;
  logic [3:0]            id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [2:0]            prot_q, prot_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            beat_q, beat_d;
  logic [DATA_WIDTH-1:0] wbeat_q, wbeat_d;
  logic                  wval_q, wval_d;
  logic                  sts_en_q, sts_en_d;
  logic [7:0]            sts_q, sts_d;
  logic [15:0]           txn_q, txn_d;
  logic [15:0]           err_q, err_d;
  logic                  pop;
  logic                  rsp_take;

  assign rsp_take = (state_q == RESP) && wr_rsp_en_d;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    prot_d   = prot_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    wbeat_d  = wbeat_q;
    wval_d   = wval_q;
    sts_en_d = 1'b0;
    sts_d    = sts_q;
    txn_d    = txn_q;
    err_d    = err_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        id_d    = fifo_dout[31:28];
        len_d   = fifo_dout[27:20];
        size_d  = fifo_dout[19:17];
        burst_d = fifo_dout[16:15];
        prot_d  = fifo_dout[14:12];
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ADDR;
        end else begin
          state_d = ADDR_POP;
        end
      end
      ADDR_POP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        addr_d  = fifo_dout[ADDR_WIDTH-1:0];
        state_d = ISSUE;
      end
      ISSUE: begin
        beat_d  = len_q;
        state_d = DATA_POP;
      end
      DATA_POP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DATA_LD;
        end
      end
      DATA_LD: begin
        wbeat_d = fifo_dout;
        wval_d  = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        if (wd_accept && wval_q) begin
          wval_d = 1'b0;
          if (beat_q == 8'd0) begin
            state_d = RESP;
          end else begin
            beat_d  = beat_q - 8'd1;
            state_d = DATA_POP;
          end
        end
      end
      RESP: begin
        if (wr_rsp_en_d) begin
          sts_en_d = 1'b1;
          sts_d    = {2'b00, bresp_d, bid_d};
          txn_d    = (txn_q == 16'hFFFF) ? txn_q : txn_q + 16'd1;
          if (bresp_d != 2'b00) begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AClk) begin
    if (ARst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      prot_q   <= '0;
      addr_q   <= '0;
      beat_q   <= '0;
      wbeat_q  <= '0;
      wval_q   <= 1'b0;
      sts_en_q <= 1'b0;
      sts_q    <= '0;
      txn_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      prot_q   <= prot_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      wbeat_q  <= wbeat_d;
      wval_q   <= wval_d;
      sts_en_q <= sts_en_d;
      sts_q    <= sts_d;
      txn_q    <= txn_d;
      err_q    <= err_d;
    end
  end

`ifdef AXI_WR_DEC_RESP_CHK_EN
  logic id_err_q, id_err_d;

  always_comb begin
    id_err_d = id_err_q;
    if (rsp_take && (bid_d != id_q)) begin
      id_err_d = 1'b1;
    end
  end

  always_ff @(posedge AClk) begin
    if (ARst) begin
      id_err_q <= 1'b0;
    end else begin
      id_err_q <= id_err_d;
    end
  end

  assign id_err = id_err_q;
`else
  assign id_err = 1'b0;
`endif

  // Pop is suppressed during reset so an in-reset cycle never consumes a FIFO word.
  assign fifo_rd_en = pop && !ARst;
  assign wr_trn_en  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign TXN_ID_W_d = id_q;
  assign awaddr_d   = addr_q;
  assign awlen_d    = len_q;
  assign awsize_d   = size_q;
  assign awburst_d  = burst_q;
  assign awlock_d   = 2'b00;
  assign awcache_d  = 2'b00;
  assign awprot_d   = prot_q;
  assign wdata_d    = wbeat_q;
  assign wstrb_d    = 4'hF;
  assign wvalid_d   = wval_q;
  assign sts_wr_en  = sts_en_q;
  assign sts_data   = sts_q;
  assign txn_cnt    = txn_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_axi_wr_cmd_decoder.sv
// Scoreboard bench for axi_wr_cmd_decoder: a FIFO model feeds commands, the bench plays the
// AXI master, and expected beats/status/attributes are queued at stimulus time.
module tb_axi_wr_cmd_decoder;

  logic        AClk = 1'b0;
  logic        ARst = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [3:0]  TXN_ID_W_d;
  logic [31:0] awaddr_d;
  logic [7:0]  awlen_d;
  logic [2:0]  awsize_d;
  logic [1:0]  awburst_d;
  logic [1:0]  awlock_d;
  logic [1:0]  awcache_d;
  logic [2:0]  awprot_d;
  logic        wr_trn_en;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic        wvalid_d;
  logic        wd_accept = 1'b0;
  logic [1:0]  bresp_d = '0;
  logic [3:0]  bid_d = '0;
  logic        wr_rsp_en_d = 1'b0;
  logic        sts_wr_en;
  logic [7:0]  sts_data;
  logic        busy;
  logic [15:0] txn_cnt;
  logic [15:0] err_cnt;
  logic        id_err;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [0:1023];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  starve = 1'b0;
  bit  underflow = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_sts_q[$];
  logic [15:0] exp_txn = '0;
  logic [15:0] exp_err = '0;
  logic        exp_id_err = 1'b0;

  always #5 AClk = ~AClk;

  assign fifo_empty = starve || (rd_ptr == wr_ptr);

  always @(posedge AClk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) underflow <= 1'b1;
      fifo_dout <= mem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  axi_wr_cmd_decoder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .AClk(AClk), .ARst(ARst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .TXN_ID_W_d(TXN_ID_W_d), .awaddr_d(awaddr_d),
    .awlen_d(awlen_d), .awsize_d(awsize_d), .awburst_d(awburst_d), .awlock_d(awlock_d),
    .awcache_d(awcache_d), .awprot_d(awprot_d), .wr_trn_en(wr_trn_en), .wdata_d(wdata_d),
    .wstrb_d(wstrb_d), .wvalid_d(wvalid_d), .wd_accept(wd_accept), .bresp_d(bresp_d),
    .bid_d(bid_d), .wr_rsp_en_d(wr_rsp_en_d), .sts_wr_en(sts_wr_en), .sts_data(sts_data),
    .busy(busy), .txn_cnt(txn_cnt), .err_cnt(err_cnt), .id_err(id_err)
  );

  task automatic fifo_push(input logic [31:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Drives one full command through the DUT, acting as the master, and checks it on the fly.
  task automatic run_txn(input string name, input logic [31:0] hdr, input logic [31:0] addr,
                         input logic [31:0] dbase, input int acc_dly, input logic [1:0] bresp,
                         input logic [3:0] bid, input int starve_n);
    logic [7:0]  len;
    logic [31:0] cur;
    logic [31:0] exp_w;
    logic [31:0] exp_a;
    logic [7:0]  exp_s;
    int trn_seen, trn_cyc, episodes, beats_done, wait_cnt, starve_left;
    bit in_beat, rsp_sent, done;
    len = hdr[27:20];
    cur = '0;
    trn_seen = 0; trn_cyc = 0; episodes = 0; beats_done = 0; wait_cnt = 0; starve_left = 0;
    in_beat = 1'b0; rsp_sent = 1'b0; done = 1'b0;
    fifo_push(hdr);
    fifo_push(addr);
    exp_addr_q.push_back(addr);
    for (int i = 0; i <= int'(len); i++) begin
      fifo_push(dbase + 32'(i));
      exp_data_q.push_back(dbase + 32'(i));
    end
    exp_sts_q.push_back({2'b00, bresp, bid});
    for (int cyc = 1; cyc <= 600 && !done; cyc++) begin
      @(negedge AClk);
      if (wd_accept) wd_accept = 1'b0;
      if (wr_trn_en) begin
        trn_seen++;
        trn_cyc = cyc;
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hx;
        total++;
        if ({TXN_ID_W_d, awaddr_d, awlen_d, awsize_d, awburst_d, awprot_d} !==
            {hdr[31:28], exp_a, len, hdr[19:17], hdr[16:15], hdr[14:12]}) begin
          bad++;
          $display("FAIL %s attrs: got id=%0h addr=%0h len=%0d size=%0d burst=%0d prot=%0d want id=%0h addr=%0h len=%0d size=%0d burst=%0d prot=%0d",
                   name, TXN_ID_W_d, awaddr_d, awlen_d, awsize_d, awburst_d, awprot_d,
                   hdr[31:28], exp_a, len, hdr[19:17], hdr[16:15], hdr[14:12]);
        end
        if (trn_seen == 1) begin
          total++;
          if (cyc !== 3) begin
            bad++;
            $display("FAIL %s trn_latency: got %0d want 3", name, cyc);
          end
        end
      end
      if (starve) begin
        total++;
        if (fifo_rd_en !== 1'b0 || wvalid_d !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s starve_hold: got rd_en=%b wvalid=%b busy=%b want 0 0 1",
                   name, fifo_rd_en, wvalid_d, busy);
        end
        starve_left--;
        if (starve_left == 0) starve = 1'b0;
      end
      if (wvalid_d) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          episodes++;
          wait_cnt = 0;
          cur = wdata_d;
          exp_w = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hx;
          total++;
          if (wdata_d !== exp_w) begin
            bad++;
            $display("FAIL %s wdata beat %0d: got %h want %h", name, episodes, wdata_d, exp_w);
          end
          if (episodes == 1) begin
            total++;
            if (cyc - trn_cyc !== 3) begin
              bad++;
              $display("FAIL %s wvalid_latency: got %0d want 3", name, cyc - trn_cyc);
            end
          end
        end else begin
          total++;
          if (wdata_d !== cur) begin
            bad++;
            $display("FAIL %s wdata_stable: got %h want %h", name, wdata_d, cur);
          end
        end
        if (wait_cnt == acc_dly) begin
          wd_accept = 1'b1;
          in_beat = 1'b0;
          beats_done++;
          if (beats_done == 1 && starve_n > 0) begin
            starve = 1'b1;
            starve_left = starve_n;
          end
        end else begin
          wait_cnt++;
        end
      end
      if (wr_rsp_en_d) begin
        wr_rsp_en_d = 1'b0;
        exp_s = (exp_sts_q.size() > 0) ? exp_sts_q.pop_front() : 8'hx;
        exp_txn = exp_txn + 16'd1;
        if (bresp != 2'b00) exp_err = exp_err + 16'd1;
`ifdef AXI_WR_DEC_RESP_CHK_EN
        if (bid != hdr[31:28]) exp_id_err = 1'b1;
`endif
        total++;
        if (sts_wr_en !== 1'b1 || sts_data !== exp_s) begin
          bad++;
          $display("FAIL %s status: got en=%b data=%h want en=1 data=%h", name, sts_wr_en, sts_data, exp_s);
        end
        total++;
        if (txn_cnt !== exp_txn || err_cnt !== exp_err || id_err !== exp_id_err) begin
          bad++;
          $display("FAIL %s counters: got txn=%0d err=%0d id_err=%b want txn=%0d err=%0d id_err=%b",
                   name, txn_cnt, err_cnt, id_err, exp_txn, exp_err, exp_id_err);
        end
        total++;
        if (awaddr_d !== addr || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s hold_after_resp: got addr=%h busy=%b want addr=%h busy=0", name, awaddr_d, busy, addr);
        end
        done = 1'b1;
      end else if (sts_wr_en) begin
        total++;
        bad++;
        $display("FAIL %s early_status: got sts_wr_en=1 want 0", name);
      end else if (!rsp_sent && beats_done == int'(len) + 1 && !wvalid_d && !wd_accept) begin
        wr_rsp_en_d = 1'b1;
        bresp_d = bresp;
        bid_d = bid;
        rsp_sent = 1'b1;
      end
    end
    wd_accept = 1'b0;
    wr_rsp_en_d = 1'b0;
    starve = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: got no status want status within 600 cycles", name);
    end
    total++;
    if (trn_seen !== 1 || episodes !== int'(len) + 1 || underflow !== 1'b0) begin
      bad++;
      $display("FAIL %s counts: got trn=%0d beats=%0d underflow=%b want trn=1 beats=%0d underflow=0",
               name, trn_seen, episodes, underflow, int'(len) + 1);
    end
    $display("txn %s: id=%0h len=%0d bresp=%0d bid=%0h done=%0b", name, hdr[31:28], len, bresp, bid, done);
  endtask

  task automatic test_reset();
    @(negedge AClk);
    total++;
    if ({fifo_rd_en, wr_trn_en, wvalid_d, sts_wr_en, busy, id_err, txn_cnt, err_cnt, sts_data, awaddr_d, wdata_d} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b txn=%0d err=%0d sts=%h addr=%h wdata=%h want all 0",
               busy, txn_cnt, err_cnt, sts_data, awaddr_d, wdata_d);
    end
    ARst = 1'b0;
    @(negedge AClk);
    total++;
    if (busy !== 1'b0 || wstrb_d !== 4'hF || awlock_d !== 2'b00 || awcache_d !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b wstrb=%h lock=%0d cache=%0d want 0 f 0 0", busy, wstrb_d, awlock_d, awcache_d);
    end
    $display("txn reset: busy=%b txn_cnt=%0d", busy, txn_cnt);
  endtask

  task automatic test_ignored();
    wd_accept = 1'b1;
    wr_rsp_en_d = 1'b1;
    bresp_d = 2'b10;
    @(negedge AClk);
    wd_accept = 1'b0;
    wr_rsp_en_d = 1'b0;
    @(negedge AClk);
    total++;
    if (sts_wr_en !== 1'b0 || txn_cnt !== exp_txn || err_cnt !== exp_err || wvalid_d !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignored_events: got sts=%b txn=%0d err=%0d wvalid=%b busy=%b want 0 %0d %0d 0 0",
               sts_wr_en, txn_cnt, err_cnt, wvalid_d, busy, exp_txn, exp_err);
    end
    $display("txn ignored: sts_wr_en=%b txn_cnt=%0d", sts_wr_en, txn_cnt);
  endtask

  task automatic test_reset_mid();
    logic [31:0] hdr;
    bit seen;
    hdr = {4'd6, 8'd3, 3'd2, 2'd1, 3'd0, 12'h000};
    seen = 1'b0;
    fifo_push(hdr);
    fifo_push(32'h0000_6000);
    for (int i = 0; i < 4; i++) fifo_push(32'h6600_0000 + 32'(i));
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge AClk);
      if (wvalid_d) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_mid_reach_data: got no wvalid want wvalid within 50 cycles");
    end
    ARst = 1'b1;
    @(negedge AClk);
    total++;
    if ({fifo_rd_en, wr_trn_en, wvalid_d, sts_wr_en, busy, id_err, txn_cnt, err_cnt, sts_data,
         awaddr_d, awlen_d, TXN_ID_W_d, awsize_d, awburst_d, awprot_d, wdata_d} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got busy=%b wvalid=%b txn=%0d addr=%h len=%0d wdata=%h want all 0",
               busy, wvalid_d, txn_cnt, awaddr_d, awlen_d, wdata_d);
    end
    ARst = 1'b0;
    wr_ptr = rd_ptr;
    exp_txn = '0;
    exp_err = '0;
    exp_id_err = 1'b0;
    $display("txn reset_mid: busy=%b", busy);
  endtask

  initial begin
    repeat (3) @(posedge AClk);
    test_reset();
    run_txn("single", 32'h3000_0000, 32'h0000_1000, 32'hDEAD_BEEF, 0, 2'b00, 4'd3, 0);
    run_txn("burst", {4'd1, 8'd3, 3'd2, 2'd1, 3'd2, 12'hABC}, 32'h0000_2000, 32'd1, 2, 2'b00, 4'd1, 0);
    run_txn("starve", {4'd2, 8'd2, 3'd2, 2'd1, 3'd5, 12'h000}, 32'h0000_3000, 32'h5000_0000, 0, 2'b00, 4'd2, 5);
    run_txn("error", 32'h3000_0000, 32'h0000_4000, 32'h1234_5678, 1, 2'b10, 4'd3, 0);
    run_txn("bid_mismatch", 32'h3000_0000, 32'h0000_5000, 32'hA000_0000, 0, 2'b00, 4'd5, 0);
    run_txn("bid_match", {4'd7, 8'd1, 3'd2, 2'd1, 3'd0, 12'h000}, 32'h0000_5100, 32'hB000_0000, 0, 2'b00, 4'd7, 0);
    test_ignored();
    test_reset_mid();
    run_txn("after_reset", {4'd9, 8'd1, 3'd1, 2'd1, 3'd1, 12'h000}, 32'h0000_7000, 32'hC000_0000, 1, 2'b01, 4'd9, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
